gray_conv_arbiter: RTL
======================

# gray_conv_arbiter

Round-robin scheduler that shares a single 4-bit Gray-to-binary conversion datapath between up to eight requesters. Each requester presents a Gray word with a level request. The arbiter grants one requester at a time, latches its operand, runs it through the shared converter and returns the registered binary result tagged with the requester index. It sits between the lab's Gray-coded sources (counters, encoders) and the binary-consuming logic, replacing one converter per source.

## Interface
Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- W, 4, Gray/binary word width; fixed at 4 to match the mux-based converter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester request level; bit i belongs to requester i.
- gray_in  input  NREQ*W  packed Gray operands; requester i occupies bits [i*W+W-1 : i*W].
- ack  output  NREQ  one-hot, one-cycle completion pulse to the served requester.
- bin_out  output  W  binary result of the last completed conversion.
- out_id  output  3  index of the requester that owns bin_out.
- out_valid  output  1  one-cycle pulse; bin_out and out_id are new this cycle.
- out_par  output  1  even-parity bit of bin_out (see Configuration).
- busy  output  1  high whenever the state is not IDLE.

## Operation
- FSM with three states: IDLE, CONV and DONE.
- IDLE: if req is nonzero, select the first set bit scanning from ptr upward with wrap at NREQ-1→0. Latch that requester's gray_in into op_reg and its index into id_reg, then go to CONV. If req is zero, stay in IDLE.
- CONV: the shared converter evaluates op_reg combinationally (B[3]=G[3], B[i]=B[i+1]^G[i]). The result is registered into bin_out, id_reg is copied to out_id, and the FSM goes to DONE.
- DONE: out_valid=1 and ack[out_id]=1 for this cycle only. Set ptr = (out_id+1) mod NREQ, then go to IDLE.
- Requests and operands are sampled only in IDLE. Changes to req or gray_in during CONV or DONE do not affect the transaction in flight.
- A requester that drops req after being granted still completes and still receives ack.
- A requester that holds req through its ack is re-eligible, but it is scanned last because ptr has moved past it.
- Bits of req at index ≥ NREQ do not exist. out_id upper bits are 0 when NREQ<8.
- bin_out, out_id and out_par hold their values between transactions.

Reset (synchronous, rst high at a rising edge):
- State goes to IDLE, ptr=0 and op_reg=0.
- bin_out=0, out_id=0, out_par=0, out_valid=0, ack=0 and busy=0.
- Reset asserted in CONV or DONE aborts the transaction: no ack is issued and the requester must re-request.

## Timing
- Latency: req is sampled high at edge T. busy is high from T through T+2. out_valid and ack are high for the single cycle between edges T+2 and T+3.
- Throughput: one conversion per 3 cycles. A new grant is possible at edge T+3.
- ack and out_valid are always coincident and never longer than one cycle.
- Requesters must hold gray_in stable in the cycle their req is sampled in IDLE; no other setup is required.
- With all NREQ requesters continuously requesting, each one is served exactly once every 3*NREQ cycles.

## Configuration
- GCA_PARITY_EN defined: out_par is registered alongside bin_out as the XOR of all bits of the binary result, so bin_out together with out_par has even parity. It updates on the same edge as bin_out and resets to 0.
- GCA_PARITY_EN undefined: out_par is tied to 0 and no parity logic is synthesized. All other behaviour is identical.

## Test plan
- Reset then single request: rst for 2 cycles, then req=4'b0001 with gray_in[3:0]=4'b1101. Expect out_valid, ack=4'b0001, bin_out=4'b1001 and out_id=0 three cycles after the sampling edge, with busy high for 3 cycles.
- Exhaustive conversion: requester 2 presents all 16 Gray codes in sequence. Each bin_out must match the XOR-chain reference, for example Gray 0110→0100 and Gray 1000→1111.
- Round-robin: req=4'b1111 held from reset. Acks arrive in order 0,1,2,3,0,… spaced 3 cycles apart, and out_id tracks the ack index.
- Fairness and pointer wrap: req[3] and req[1] held with ptr=0. Grants alternate 1,3,1,3, and no requester is granted twice in a row while the other waits.
- Reset mid-operation: assert rst during CONV for requester 1. Expect no ack, all outputs 0 and ptr=0. After release, req[1] is re-served first.
- Parity (with GCA_PARITY_EN): Gray 0110 gives bin 0100 and out_par=1; Gray 0101 gives bin 0110 and out_par=0. Rebuilt without the macro, out_par must stay 0 throughout.

Source files
------------

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one Gray-to-binary converter among NREQ requesters.
// Define GCA_PARITY_EN to register an even-parity bit (out_par) alongside bin_out.
module gray_conv_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] gray_in,
    output logic [NREQ-1:0]   ack,
    output logic [W-1:0]      bin_out,
    output logic [2:0]        out_id,
    output logic              out_valid,
    output logic              out_par,
    output logic              busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int unsigned NR = NREQ;

    logic [1:0]     state;
    logic [2:0]     ptr;
    logic [2:0]     id_reg;
    logic [2:0]     grant_idx;
    logic [2:0]     cand;
    logic [2:0]     next_ptr;
    logic           grant_found;
    logic [W-1:0]   op_reg;
    logic [W-1:0]   conv_bin;
    logic [7:0]     req8;
    logic [8*W-1:0] gray8;
    logic [W-1:0]   gray_arr [8];

    // Widen to the full 8-requester space so a 3-bit index never selects out of range.
    assign req8  = 8'(req);
    assign gray8 = (8*W)'(gray_in);

    always_comb begin
        for (int unsigned i = 0; i < 8; i++) begin
            gray_arr[i] = gray8[i*W +: W];
        end
    end

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 0; k < NR; k++) begin
            cand = 3'((32'(ptr) + k) % NR);
            if (!grant_found && req8[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // B[i] is the XOR of G[W-1:i].
    always_comb begin
        conv_bin = '0;
        for (int unsigned j = 0; j < W; j++) begin
            conv_bin[j] = ^(op_reg >> j);
        end
    end

    assign next_ptr = (out_id == 3'(NREQ - 1)) ? 3'd0 : out_id + 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            op_reg    <= '0;
            id_reg    <= '0;
            bin_out   <= '0;
            out_id    <= '0;
            out_valid <= 1'b0;
            ack       <= '0;
        end else begin
            out_valid <= 1'b0;
            ack       <= '0;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        op_reg <= gray_arr[grant_idx];
                        id_reg <= grant_idx;
                        state  <= CONV;
                    end
                end
                CONV: begin
                    bin_out <= conv_bin;
                    out_id  <= id_reg;
                    state   <= DONE;
                end
                DONE: begin
                    out_valid <= 1'b1;
                    ack       <= NREQ'(1) << out_id;
                    ptr       <= next_ptr;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The completion pulse is registered out of DONE, so busy also covers that pulse cycle.
    assign busy = (state != IDLE) || out_valid;

`ifdef GCA_PARITY_EN
    logic par_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            par_reg <= 1'b0;
        end else if (state == CONV) begin
            par_reg <= ^conv_bin;
        end
    end

    assign out_par = par_reg;
`else
    assign out_par = 1'b0;
`endif

endmodule
